// File: rtl/mopshub_pwr_pkg.sv
// Shared types and 40 MHz timing defaults for the MOPSHUB bus power-up sequencer.
package mopshub_pwr_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_POWER_ON, ST_SETTLE, ST_BUS_RST,
    ST_TRIM_REQ, ST_TRIM_WAIT, ST_NEXT, ST_DONE
  } pwr_state_t;

  localparam int SETTLE_CYCLES_40M = 400;    // 10 us
  localparam int RST_CYCLES_40M    = 4;
  localparam int TRIM_TIMEOUT_40M  = 40000;  // 1 ms
endpackage

// File: rtl/pwr_down_counter.sv
// Loadable down-counter that parks at zero; o_zero flags the terminal count.
module pwr_down_counter #(
  parameter int W = 8
) (
  input  logic         clk_40_m,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_40_m) begin
    if (!rst)                     r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/power_bus_sequencer.sv
// Powers MOPSHUB CAN buses 0..n_buses one at a time: enable, settle, reset pulse,
// optional oscillator trim with timeout. All outputs come straight from flops.
module power_bus_sequencer
  import mopshub_pwr_pkg::*;
#(
  parameter int N_BUSES       = 32,
  parameter int CNT_W         = $clog2(N_BUSES),
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_40M,
  parameter int RST_CYCLES    = RST_CYCLES_40M,
  parameter int TRIM_TIMEOUT  = TRIM_TIMEOUT_40M
) (
  input  logic               clk_40_m,
  input  logic               rst,
  input  logic               start_init,
  input  logic [CNT_W-1:0]   n_buses,
  input  logic               osc_auto_trim,
  input  logic               end_trim_bus,
  output logic               power_bus_en,
  output logic [CNT_W-1:0]   power_bus_cnt,
  output logic [N_BUSES-1:0] power_mask,
  output logic               rst_bus,
  output logic               start_trim_ack,
  output logic [N_BUSES-1:0] trim_timeout_mask,
  output logic               busy,
  output logic               end_power_init
);
  localparam int ST_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
  localparam int SW     = $clog2(ST_MAX + 1);
  localparam int TW     = $clog2(TRIM_TIMEOUT + 1);
  localparam logic [CNT_W:0] LAST_MAX = (CNT_W+1)'(N_BUSES - 1);

  pwr_state_t         r_state;
  logic [CNT_W-1:0]   r_last_q;
  logic               r_trim_q;
  logic               r_power_bus_en;
  logic [CNT_W-1:0]   r_bus_cnt;
  logic [N_BUSES-1:0] r_power_mask;
  logic               r_rst_bus;
  logic               r_trim_ack;
  logic [N_BUSES-1:0] r_to_mask;
  logic               r_busy;
  logic               r_end;

  logic          w_st_load, w_st_en, w_st_zero;
  logic [SW-1:0] w_st_val;
  logic          w_tr_load, w_tr_en, w_tr_zero;

  // One counter times both the settle window and the reset pulse back to back.
  assign w_st_load = (r_state == ST_POWER_ON) || (r_state == ST_SETTLE && w_st_zero);
  assign w_st_val  = (r_state == ST_POWER_ON) ? SW'(SETTLE_CYCLES - 1) : SW'(RST_CYCLES - 1);
  assign w_st_en   = (r_state == ST_SETTLE) || (r_state == ST_BUS_RST);

  // Timeout window starts with the request cycle so the wait totals TRIM_TIMEOUT cycles.
  assign w_tr_load = (r_state == ST_BUS_RST) && w_st_zero && r_trim_q;
  assign w_tr_en   = (r_state == ST_TRIM_REQ) || (r_state == ST_TRIM_WAIT);

  pwr_down_counter #(.W(SW)) u_settle_cnt (
    .clk_40_m(clk_40_m), .rst(rst), .i_load(w_st_load), .i_load_val(w_st_val),
    .i_en(w_st_en), .o_zero(w_st_zero)
  );

  pwr_down_counter #(.W(TW)) u_trim_cnt (
    .clk_40_m(clk_40_m), .rst(rst), .i_load(w_tr_load), .i_load_val(TW'(TRIM_TIMEOUT - 1)),
    .i_en(w_tr_en), .o_zero(w_tr_zero)
  );

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_last_q       <= '0;
      r_trim_q       <= 1'b0;
      r_power_bus_en <= 1'b0;
      r_bus_cnt      <= '0;
      r_power_mask   <= '0;
      r_rst_bus      <= 1'b0;
      r_trim_ack     <= 1'b0;
      r_to_mask      <= '0;
      r_busy         <= 1'b0;
      r_end          <= 1'b0;
    end else begin
      r_trim_ack <= 1'b0;
      r_end      <= 1'b0;
      case (r_state)
        ST_IDLE: if (start_init) begin
          r_last_q       <= ({1'b0, n_buses} > LAST_MAX) ? LAST_MAX[CNT_W-1:0] : n_buses;
          r_trim_q       <= osc_auto_trim;
          r_bus_cnt      <= '0;
          r_power_mask   <= '0;
          r_to_mask      <= '0;
          r_power_bus_en <= 1'b1;
          r_busy         <= 1'b1;
          r_state        <= ST_POWER_ON;
        end
        ST_POWER_ON: begin
          r_power_mask[r_bus_cnt] <= 1'b1;
          r_state                 <= ST_SETTLE;
        end
        ST_SETTLE: if (w_st_zero) begin
          r_rst_bus <= 1'b1;
          r_state   <= ST_BUS_RST;
        end
        ST_BUS_RST: if (w_st_zero) begin
          r_rst_bus <= 1'b0;
          if (r_trim_q) begin
            r_trim_ack <= 1'b1;
            r_state    <= ST_TRIM_REQ;
          end else begin
            r_power_bus_en <= 1'b0;
            r_state        <= ST_NEXT;
          end
        end
        ST_TRIM_REQ: r_state <= ST_TRIM_WAIT;
        ST_TRIM_WAIT: if (end_trim_bus || w_tr_zero) begin
          // A late ack in the terminal cycle still counts as success.
          if (!end_trim_bus) r_to_mask[r_bus_cnt] <= 1'b1;
          r_power_bus_en <= 1'b0;
          r_state        <= ST_NEXT;
        end
        ST_NEXT: if (r_bus_cnt == r_last_q) begin
          r_busy  <= 1'b0;
          r_end   <= 1'b1;
          r_state <= ST_DONE;
        end else begin
          r_bus_cnt      <= r_bus_cnt + 1'b1;
          r_power_bus_en <= 1'b1;
          r_state        <= ST_POWER_ON;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign power_bus_en      = r_power_bus_en;
  assign power_bus_cnt     = r_bus_cnt;
  assign power_mask        = r_power_mask;
  assign rst_bus           = r_rst_bus;
  assign start_trim_ack    = r_trim_ack;
  assign trim_timeout_mask = r_to_mask;
  assign busy              = r_busy;
  assign end_power_init    = r_end;
endmodule
